// File: rtl/vga2_pkg.sv
// Shared widths, the tag-entry payload and the lane byte-select helper for the vga2 pixel read stage.
package vga2_pkg;

    localparam int unsigned MODE_SOLID_BIT = 0;
    localparam int unsigned COLOR_W        = 24;
    localparam int unsigned WORD_ADDR_W    = 24;
    localparam int unsigned X_W            = 10;
    localparam int unsigned Z_W            = 12;
    localparam int unsigned MODE_W         = 5;
    localparam int unsigned ADDR_W         = 26;
    localparam int unsigned DATA_W         = 32;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Z_W-1:0]     z;
        logic [MODE_W-1:0]  mode;
        logic [1:0]         lane;
        logic [COLOR_W-1:0] addr;
        logic               needs_data;
        logic               reuse;
    } tag_t;

    // Little-endian byte select: lane 0 is bits 7:0.
    function automatic logic [7:0] lane_byte(input logic [DATA_W-1:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/vga2_fifo.sv
// Generic synchronous FIFO with show-ahead read data; pushes when full and pops when empty are ignored.
module vga2_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q[PTR_W-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_q <= rd_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q[PTR_W-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/vga2_memread.sv
// Pixel read stage: issues texture word reads, pairs in-order responses with queued pixels, emits colours.
// Optional same-word request coalescing is enabled by defining VGA2_MEMREAD_COALESCE_EN.
module vga2_memread
    import vga2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   memread_valid,
    output logic                   memread_ready,
    input  logic [X_W-1:0]         memread_x,
    input  logic [Z_W-1:0]         memread_z,
    input  logic [MODE_W-1:0]      memread_mode,
    input  logic [ADDR_W-1:0]      memread_addr,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [WORD_ADDR_W-1:0] mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [DATA_W-1:0]      mem_resp_data,
    output logic                   blend_valid,
    input  logic                   blend_ready,
    output logic [X_W-1:0]         blend_x,
    output logic [Z_W-1:0]         blend_z,
    output logic [MODE_W-1:0]      blend_mode,
    output logic [COLOR_W-1:0]     blend_color
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    tag_t               push_tag, head_tag;
    logic               tag_full, tag_empty, resp_full, resp_empty;
    logic [DATA_W-1:0]  resp_word, word_sel, last_word_q;
    logic               coalesce_hit, is_solid, accept, req_fire, resp_take;
    logic               out_free, tag_pop, resp_pop;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [COLOR_W-1:0] color_d;

    logic               blend_valid_q;
    logic [X_W-1:0]     blend_x_q;
    logic [Z_W-1:0]     blend_z_q;
    logic [MODE_W-1:0]  blend_mode_q;
    logic [COLOR_W-1:0] blend_color_q;

    assign is_solid      = memread_mode[MODE_SOLID_BIT];
    assign memread_ready = reset && !tag_full && (is_solid || mem_req_ready || coalesce_hit);
    assign mem_req_valid = reset && memread_valid && !is_solid && !tag_full && !coalesce_hit;
    assign mem_req_addr  = memread_addr[ADDR_W-1:2];
    assign accept        = memread_valid && memread_ready;
    assign req_fire      = mem_req_valid && mem_req_ready;

`ifdef VGA2_MEMREAD_COALESCE_EN
    logic                   trk_valid_q;
    logic [WORD_ADDR_W-1:0] trk_addr_q;

    assign coalesce_hit = trk_valid_q && !is_solid && (trk_addr_q == memread_addr[ADDR_W-1:2]);

    // Tracks the word address of the most recently issued read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trk_valid_q <= 1'b0;
            trk_addr_q  <= '0;
        end else if (req_fire) begin
            trk_valid_q <= 1'b1;
            trk_addr_q  <= memread_addr[ADDR_W-1:2];
        end
    end
`else
    assign coalesce_hit = 1'b0;
`endif

    always_comb begin
        push_tag            = '0;
        push_tag.x          = memread_x;
        push_tag.z          = memread_z;
        push_tag.mode       = memread_mode;
        push_tag.lane       = memread_addr[1:0];
        push_tag.addr       = memread_addr[COLOR_W-1:0];
        push_tag.needs_data = !is_solid && !coalesce_hit;
        push_tag.reuse      = !is_solid && coalesce_hit;
    end

    vga2_fifo #(.WIDTH($bits(tag_t)), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (accept),
        .wdata_i (push_tag),
        .pop_i   (tag_pop),
        .rdata_o (head_tag),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    // Responses without an outstanding read are dropped rather than queued.
    assign resp_take = mem_resp_valid && (outst_q != '0) && !resp_full;

    vga2_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (resp_take),
        .wdata_i (mem_resp_data),
        .pop_i   (resp_pop),
        .rdata_o (resp_word),
        .full_o  (resp_full),
        .empty_o (resp_empty)
    );

    always_comb begin
        outst_d = outst_q;
        if (req_fire && !resp_take)      outst_d = outst_q + CNT_W'(1);
        else if (!req_fire && resp_take) outst_d = outst_q - CNT_W'(1);
    end

    assign out_free = !blend_valid_q || blend_ready;
    assign tag_pop  = !tag_empty && out_free && (!head_tag.needs_data || !resp_empty);
    assign resp_pop = tag_pop && head_tag.needs_data;

    always_comb begin
        word_sel = head_tag.reuse ? last_word_q : resp_word;
        if (head_tag.mode[MODE_SOLID_BIT]) color_d = head_tag.addr;
        else                               color_d = {16'h0, lane_byte(word_sel, head_tag.lane)};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outst_q       <= '0;
            last_word_q   <= '0;
            blend_valid_q <= 1'b0;
            blend_x_q     <= '0;
            blend_z_q     <= '0;
            blend_mode_q  <= '0;
            blend_color_q <= '0;
        end else begin
            outst_q <= outst_d;
            if (resp_pop) last_word_q <= resp_word;
            if (tag_pop) begin
                blend_valid_q <= 1'b1;
                blend_x_q     <= head_tag.x;
                blend_z_q     <= head_tag.z;
                blend_mode_q  <= head_tag.mode;
                blend_color_q <= color_d;
            end else if (blend_ready) begin
                blend_valid_q <= 1'b0;
            end
        end
    end

    assign blend_valid = blend_valid_q;
    assign blend_x     = blend_x_q;
    assign blend_z     = blend_z_q;
    assign blend_mode  = blend_mode_q;
    assign blend_color = blend_color_q;

endmodule

// File: tb/tb_vga2_memread.sv
// Table-driven bench for vga2_memread: pixel vectors with hand-computed colours, an in-order
// scoreboard, a delayed-response memory model and directed latency/backpressure/reset sequences.
module tb_vga2_memread;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        memread_valid = 1'b0;
    logic        memread_ready;
    logic [9:0]  memread_x = '0;
    logic [11:0] memread_z = '0;
    logic [4:0]  memread_mode = '0;
    logic [25:0] memread_addr = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [23:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        blend_valid;
    logic        blend_ready = 1'b1;
    logic [9:0]  blend_x;
    logic [11:0] blend_z;
    logic [4:0]  blend_mode;
    logic [23:0] blend_color;

    always #5 clock = ~clock;

    vga2_memread #(.FIFO_DEPTH(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .memread_valid  (memread_valid),
        .memread_ready  (memread_ready),
        .memread_x      (memread_x),
        .memread_z      (memread_z),
        .memread_mode   (memread_mode),
        .memread_addr   (memread_addr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .blend_valid    (blend_valid),
        .blend_ready    (blend_ready),
        .blend_x        (blend_x),
        .blend_z        (blend_z),
        .blend_mode     (blend_mode),
        .blend_color    (blend_color)
    );

    typedef struct {
        logic [9:0]  x;
        logic [11:0] z;
        logic [4:0]  mode;
        logic [25:0] addr;
        logic [23:0] color;
    } vec_t;

    vec_t        vec [34];
    vec_t        cur;
    vec_t        exp_q [$];
    logic [23:0] mq_addr [$];
    int          mq_due [$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          n_req = 0;
    int          n_acc = 0;
    int          n_out = 0;
    int          resp_delay = 0;
    logic [23:0] last_req_addr = '0;
    logic        bp_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic vec_t mk(input logic [9:0] x, input logic [11:0] z, input logic [4:0] mode,
                                input logic [25:0] addr, input logic [23:0] color);
        vec_t v;
        v.x = x; v.z = z; v.mode = mode; v.addr = addr; v.color = color;
        return v;
    endfunction

    // Memory contents: word 0x40 is 44332211, every other word holds bytes w, w+1, w+2, w+3 in lanes 0..3.
    function automatic logic [31:0] mem_word(input logic [23:0] w);
        if (w == 24'h40) return 32'h44332211;
        return {w[7:0] + 8'd3, w[7:0] + 8'd2, w[7:0] + 8'd1, w[7:0]};
    endfunction

    // Memory model and scoreboard: drive at negedge, sample settled handshakes 1 time unit later.
    always @(negedge clock) begin
        vec_t e;
        cyc++;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(mq_addr[0]);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        #1;
        if (reset) begin
            if (mem_resp_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (mem_req_valid && mem_req_ready) begin
                mq_addr.push_back(mem_req_addr);
                mq_due.push_back(cyc + 1 + resp_delay);
                last_req_addr = mem_req_addr;
                n_req++;
            end
            if (memread_valid && memread_ready) begin
                exp_q.push_back(cur);
                n_acc++;
            end
            if (blend_valid && blend_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got x=%0d color=%0h, no pixel pending", blend_x, blend_color);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("pixel%0d", n_out), 64'({blend_x, blend_z, blend_mode, blend_color}),
                        64'({e.x, e.z, e.mode, e.color}));
                end
                n_out++;
            end
        end
    end

    task automatic send(input vec_t v);
        int t = 0;
        @(negedge clock);
        memread_valid = 1'b1;
        memread_x     = v.x;
        memread_z     = v.z;
        memread_mode  = v.mode;
        memread_addr  = v.addr;
        cur           = v;
        #2;
        while (!memread_ready && t < 200) begin
            @(negedge clock);
            #2;
            t++;
        end
        if (t >= 200) begin
            checks++;
            $display("FAIL send_timeout: x=%0d still not accepted after %0d cycles", v.x, t);
        end
    endtask

    task automatic idle();
        @(negedge clock);
        memread_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (t >= 300) begin
            checks++;
            $display("FAIL %s_drain: %0d pixels still pending, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0, a0, o0, t0, t;
        logic [23:0] tp_col [8];

        vec[0] = mk(10'd5,  12'h123, 5'b00001, 26'h0ABCDEF, 24'hABCDEF);
        vec[1] = mk(10'd10, 12'h000, 5'b00000, 26'h0000100, 24'h000011);
        vec[2] = mk(10'd11, 12'h001, 5'b00000, 26'h0000101, 24'h000022);
        vec[3] = mk(10'd12, 12'h002, 5'b00000, 26'h0000102, 24'h000033);
        vec[4] = mk(10'd13, 12'h003, 5'b00000, 26'h0000103, 24'h000044);
        vec[5] = mk(10'd20, 12'h7FF, 5'b00010, 26'h0000208, 24'h000082);
        vec[6] = mk(10'd21, 12'h010, 5'b10001, 26'h3123456, 24'h123456);
        vec[7] = mk(10'd22, 12'hFFF, 5'b00100, 26'h000030E, 24'h0000C5);
        tp_col = '{24'h00, 24'h02, 24'h04, 24'h06, 24'h04, 24'h06, 24'h08, 24'h0A};
        for (int i = 0; i < 8; i++)
            vec[8+i] = mk(10'(100 + i), 12'(i), 5'b00000, 26'(26'h400 + 4*i + (i % 4)), tp_col[i]);
        for (int i = 0; i < 12; i++)
            vec[16+i] = mk(10'(200 + i), 12'(3*i), 5'b00001, 26'(26'h0100000 + i), 24'(24'h100000 + i));
        for (int i = 0; i < 3; i++)
            vec[28+i] = mk(10'(30 + i), 12'h0, 5'b00001, 26'(26'hAA + i), 24'(24'hAA + i));
        vec[31] = mk(10'd33, 12'h0, 5'b00000, 26'h0000600, 24'h000080);
        vec[32] = mk(10'd34, 12'h0, 5'b00000, 26'h0000604, 24'h000081);
        vec[33] = mk(10'd7,  12'h055, 5'b00011, 26'h2FEDCBA, 24'hFEDCBA);

        // Reset state, with a texture pixel offered so the ready/request gating is exercised.
        memread_valid = 1'b1;
        memread_mode  = 5'b00000;
        memread_addr  = 26'h0000100;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_blend_valid", 64'(blend_valid), 64'(0));
        chk("rst_memread_ready", 64'(memread_ready), 64'(0));
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_blend_fields", 64'({blend_x, blend_z, blend_mode, blend_color}), 64'(0));
        memread_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Solid pixel latency on an idle pipe.
        n0 = n_req;
        send(vec[0]);
        @(negedge clock);
        memread_valid = 1'b0;
        #1;
        chk("solid_lat_edgeE", 64'(blend_valid), 64'(0));
        @(negedge clock);
        #1;
        chk("solid_lat_edgeE1", 64'(blend_valid), 64'(1));
        chk("solid_color", 64'(blend_color), 64'(24'hABCDEF));
        chk("solid_no_req", 64'(n_req - n0), 64'(0));
        drain("solid");

        // Four texture reads of the same word, one per lane.
        n0 = n_req;
        for (int i = 1; i <= 4; i++) send(vec[i]);
        idle();
        drain("tex4");
`ifdef VGA2_MEMREAD_COALESCE_EN
        chk("tex4_req_count", 64'(n_req - n0), 64'(1));
`else
        chk("tex4_req_count", 64'(n_req - n0), 64'(4));
`endif
        chk("tex4_req_addr", 64'(last_req_addr), 64'(24'h40));

        // Texture/solid/texture with slow memory: the solid must wait its turn.
        resp_delay = 10;
        o0 = n_out;
        for (int i = 5; i <= 7; i++) send(vec[i]);
        idle();
        repeat (5) @(negedge clock);
        #3;
        chk("interleave_solid_waits", 64'(n_out - o0), 64'(0));
        drain("interleave");
        chk("interleave_count", 64'(n_out - o0), 64'(3));
        resp_delay = 0;

        // Sustained one pixel per cycle.
        #3;
        t0 = cyc;
        o0 = n_out;
        for (int i = 8; i < 16; i++) send(vec[i]);
        chk("throughput_accept_cycles", 64'(cyc - t0), 64'(8));
        idle();
        drain("throughput");
        chk("throughput_count", 64'(n_out - o0), 64'(8));

        // Downstream stall: 8 tags plus one held output, then in-order drain.
        @(negedge clock);
        blend_ready = 1'b0;
        a0 = n_acc;
        o0 = n_out;
        fork
            begin
                for (int i = 16; i < 28; i++) send(vec[i]);
                idle();
                bp_done = 1'b1;
            end
        join_none
        repeat (20) @(negedge clock);
        #3;
        chk("bp_accepts", 64'(n_acc - a0), 64'(9));
        chk("bp_ready_low", 64'(memread_ready), 64'(0));
        chk("bp_req_low", 64'(mem_req_valid), 64'(0));
        chk("bp_hold", 64'({blend_valid, blend_x, blend_color}), 64'({1'b1, vec[16].x, vec[16].color}));
        @(negedge clock);
        blend_ready = 1'b1;
        t = 0;
        while (!bp_done && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (!bp_done) begin
            checks++;
            $display("FAIL bp_driver_done: driver still blocked after %0d cycles", t);
        end
        drain("bp");
        chk("bp_outputs", 64'(n_out - o0), 64'(12));

        // Reset with pixels in flight.
        blend_ready = 1'b0;
        resp_delay  = 10;
        for (int i = 28; i < 33; i++) send(vec[i]);
        idle();
        repeat (2) @(negedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_blend_valid", 64'(blend_valid), 64'(0));
        chk("mid_rst_memread_ready", 64'(memread_ready), 64'(0));
        chk("mid_rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        exp_q.delete();
        mq_addr.delete();
        mq_due.delete();
        repeat (2) @(negedge clock);
        reset       = 1'b1;
        blend_ready = 1'b1;
        resp_delay  = 0;
        o0 = n_out;
        repeat (3) @(negedge clock);
        #3;
        chk("post_rst_empty", 64'({blend_valid, 32'(n_out - o0)}), 64'(0));
        send(vec[33]);
        @(negedge clock);
        memread_valid = 1'b0;
        #1;
        chk("post_rst_lat_edgeE", 64'(blend_valid), 64'(0));
        @(negedge clock);
        #1;
        chk("post_rst_lat_edgeE1", 64'({blend_valid, blend_color}), 64'({1'b1, 24'hFEDCBA}));
        drain("post_rst");
        chk("post_rst_count", 64'(n_out - o0), 64'(1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vga2_memread.md
VGA2_MEMREAD -- requirements
Module: vga2_memread

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning max in-flight pixels (power of two, >=2).
REQ-002 SHALL have clock  in  1  rising-edge clock for all state.
REQ-003 SHALL have reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have memread_valid in 1, memread_ready out 1: upstream pixel handshake.
REQ-005 SHALL have memread_x in 10, memread_z in 12, memread_mode in 5, memread_addr in 26: upstream pixel; mode[0]=1 means addr[23:0] is RGB colour, else byte address.
REQ-006 SHALL have mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out 24: word-read request, word address = addr[25:2].
REQ-007 SHALL have mem_resp_valid in 1, mem_resp_data in 32: in-order read data, no backpressure.
REQ-008 SHALL have blend_valid out 1, blend_ready in 1, blend_x out 10, blend_z out 12, blend_mode out 5, blend_color out 24: downstream pixel.

Function
REQ-009 Accept = memread_valid & memread_ready; memread_ready = !tag_full & (mode[0] | mem_req_ready | coalesce_hit).
REQ-010 mem_req_valid = memread_valid & !mode[0] & !tag_full & !coalesce_hit; SHALL NOT depend on mem_req_ready.
REQ-011 Each accepted pixel SHALL push one tag entry {x, z, mode, addr[1:0], addr[23:0], needs_data, reuse}.
REQ-012 Each mem_resp_valid cycle SHALL push mem_resp_data into a response FIFO of FIFO_DEPTH; never overflows since outstanding reads <= tag entries.
REQ-013 Head tag SHALL pop when output register free (!blend_valid | blend_ready) and (!needs_data | response FIFO non-empty); a needs_data pop also pops one response word.
REQ-014 blend_color: solid -> addr[23:0]; texture -> {16'h0, word byte at lane addr[1:0]} (lane 0 = bits 7:0, little-endian).
REQ-015 Output order SHALL equal acceptance order regardless of mode mix.
REQ-016 blend_* registered; held stable while blend_valid & !blend_ready.
REQ-017 Latency, empty pipe, no stall: solid pixel accepted at edge E -> blend_valid after edge E+1; texture -> blend_valid after edge following response capture +1.
REQ-018 Throughput: one pixel/cycle sustained when memory returns one word/cycle and blend_ready=1.
REQ-019 Tag full: memread_ready=0, mem_req_valid=0; simultaneous pop and push when full SHALL still block push (no full-bypass).
REQ-020 mem_resp_valid with no outstanding read is a protocol violation; data discarded, bench asserts.
REQ-021 Pointers wrap modulo FIFO_DEPTH; full/empty via extra pointer MSB.

Reset
REQ-022 While reset=0: blend_valid=0, mem_req_valid=0, memread_ready=0, both FIFOs empty, coalesce tracker invalid; blend_x/z/mode/color=0.
REQ-023 Reset mid-operation SHALL discard all in-flight pixels; memory subsystem shares reset so no pre-reset responses arrive.

Configuration
REQ-024 Macro VGA2_MEMREAD_COALESCE_EN.
REQ-025 Defined: texture pixel whose word address equals last issued texture word address (tracker valid) SHALL issue no request, enqueue reuse=1, and use last word delivered to output; solid pixels do not disturb tracker.
REQ-026 Undefined: coalesce_hit=0, reuse never set, every texture pixel issues one request.

Structure
REQ-027 vga2_pkg SHALL hold tag-entry struct, MODE_SOLID_BIT=0, COLOR_W=24, WORD_ADDR_W=24.
REQ-028 Sub-module vga2_fifo (generic sync FIFO, WIDTH/DEPTH params, async active-low reset) instantiated twice: tags, responses.

Verification
REQ-029 Solid addr=26'h0ABCDEF, x=5, idle pipe -> blend_color=24'hABCDEF, x=5, blend_valid after edge E+1, no mem_req.
REQ-030 Texture addrs 0x100,0x101,0x102,0x103 (macro off), resp 32'h44332211 each -> colours 0x11,0x22,0x33,0x44, 4 requests addr 24'h40.
REQ-031 Same stream with VGA2_MEMREAD_COALESCE_EN -> 1 request, same 4 colours.
REQ-032 Interleave texture/solid/texture, response delayed 10 cycles -> output order preserved, solid waits behind texture.
REQ-033 blend_ready=0 for 20 cycles, 12 pixels offered, depth 8 -> memread_ready drops after 8 accepts + 1 output held, no loss, then drains in order.
REQ-034 reset asserted with 5 in flight -> blend_valid=0 immediately; after release FIFOs empty, new solid pixel passes with REQ-017 latency.
